bist_fail_logger: RTL

//  Downstream consumer of the MBIST controller's per-read compare stream.

---
 rtl/bist_fail_logger.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bist_fail_logger.sv
// MBIST compare-stream consumer: counts read mismatches, logs the first few
// failures in a small FIFO for the host, and publishes a pass/fail verdict.
module bist_fail_logger #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 4,
  parameter int LOG_DEPTH = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 done,
  input  logic                 chk_valid,
  input  logic [3:0]           chk_elem,
  input  logic [AWIDTH-1:0]    chk_addr,
  input  logic [DWIDTH-1:0]    chk_expect,
  input  logic [DWIDTH-1:0]    chk_data,
  output logic                 log_valid,
  input  logic                 log_ready,
  output logic [3:0]           log_elem,
  output logic [AWIDTH-1:0]    log_addr,
  output logic [DWIDTH-1:0]    log_syndrome,
  output logic [CNT_WIDTH-1:0] fail_count,
  output logic                 overflow,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 pass
);

  localparam int PW = $clog2(LOG_DEPTH);
  localparam int EW = 4 + AWIDTH + DWIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] fail_count_q, fail_count_d;
  logic                 overflow_q, overflow_d;
  logic                 pass_q, pass_d;
  logic [PW:0]          wr_ptr_q, wr_ptr_d;
  logic [PW:0]          rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]        mem_q [LOG_DEPTH];

  logic [DWIDTH-1:0]    syndrome;
  logic [EW-1:0]        head;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 mismatch;
  logic                 push;

  assign syndrome   = chk_data ^ chk_expect;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop        = !fifo_empty && log_ready;
  // A strobe coinciding with start belongs to no run and is dropped.
  assign mismatch   = (state_q == S_RUN) && !start && chk_valid && (|syndrome);
  // A pop in the same cycle frees the slot the push needs when full.
  assign push       = mismatch && (!fifo_full || pop);

  always_comb begin
    state_d      = state_q;
    fail_count_d = fail_count_q;
    overflow_d   = overflow_q;
    pass_d       = pass_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    if (mismatch) begin
      if (fail_count_q != '1) fail_count_d = fail_count_q + CNT_WIDTH'(1);
      if (!push) overflow_d = 1'b1;
    end

    case (state_q)
      S_IDLE: ;
      S_RUN: begin
        if (done) begin
          state_d = S_DONE;
          pass_d  = (fail_count_d == '0);
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d      = S_RUN;
      fail_count_d = '0;
      overflow_d   = 1'b0;
      pass_d       = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fail_count_q <= '0;
      overflow_q   <= 1'b0;
      pass_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fail_count_q <= fail_count_d;
      overflow_q   <= overflow_d;
      pass_q       <= pass_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Log storage has no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= {chk_elem, chk_addr, syndrome};
  end

  assign head         = mem_q[rd_ptr_q[PW-1:0]];
  assign log_valid    = !fifo_empty;
  assign log_elem     = log_valid ? head[EW-1 -: 4]           : '0;
  assign log_addr     = log_valid ? head[DWIDTH +: AWIDTH]    : '0;
  assign log_syndrome = log_valid ? head[DWIDTH-1:0]          : '0;

  assign fail_count   = fail_count_q;
  assign overflow     = overflow_q;
  assign pass         = pass_q;
  assign busy         = (state_q == S_RUN);
  assign result_valid = (state_q == S_DONE);

endmodule
